// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants and FSM state type for the MII receive path
// Purpose: nibble codes, broadcast address, CRC-32 constants and the rx FSM enum.
// Ports: none (package).
package eth_pkg;

  localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  ETH_SFD_NIB      = 4'hD;
  localparam logic [47:0] ETH_BCAST_MAC    = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] ETH_CRC_POLY     = 32'h04C1_1DB7;
  localparam logic [31:0] ETH_CRC_RESIDUE  = 32'hC704_DD7B;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/eth_crc32_d4.sv
// rtl/eth_crc32_d4.sv - CRC-32 register advanced by one MII nibble per cycle
// Purpose: MSB-first CRC-32 (poly 04C11DB7, init all ones) fed with the bits of
//   each nibble in wire order (d[0] first), so a good frame including its FCS
//   leaves the register at ETH_CRC_RESIDUE.
// Ports:
//   i_clk   in  1   clock
//   i_rst   in  1   synchronous active-low reset (register to all ones)
//   i_init  in  1   reload all ones (start of frame)
//   i_en    in  1   fold i_d into the register this cycle
//   i_d     in  4   data nibble
//   o_crc   out 32  current register value
module eth_crc32_d4
  import eth_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [3:0]  i_d,
  output logic [31:0] o_crc
);

  logic [31:0] r_crc;
  logic [31:0] w_crc_nxt;

  always_comb begin
    w_crc_nxt = r_crc;
    for (int i = 0; i < 4; i++) begin
      if (w_crc_nxt[31] ^ i_d[i]) begin
        w_crc_nxt = {w_crc_nxt[30:0], 1'b0} ^ ETH_CRC_POLY;
      end else begin
        w_crc_nxt = {w_crc_nxt[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_init) begin
      r_crc <= '1;
    end else if (i_en) begin
      r_crc <= w_crc_nxt;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/ethernet_rx.sv
// rtl/ethernet_rx.sv - MII receive path: preamble/SFD hunt, byte assembly, FCS strip
// Purpose: hunts preamble+SFD, assembles bytes low nibble first, streams payload
//   bytes (DA first, FCS stripped via a 4-byte delay line) and flags each frame
//   good/bad at end of frame. Optional CRC check: define ETH_RX_CRC_CHECK_EN.
// Ports:
//   i_clk          in  1   25 MHz MII rx clock
//   i_rst          in  1   synchronous active-low reset
//   i_rx_ctrl      in  1   PHY receive data valid
//   i_phy_rxd      in  4   PHY receive nibble
//   o_dataout      out 8   payload byte
//   o_data_valid   out 1   one-cycle strobe, o_dataout valid
//   o_frame_start  out 1   with o_data_valid of the first byte of a frame
//   o_frame_end    out 1   one-cycle pulse after frame completes or aborts
//   o_frame_ok     out 1   frame verdict, valid only with o_frame_end
//   o_byte_count   out 11  bytes received incl. FCS, held until next SFD
module ethernet_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC       = 48'h00_0A_35_01_02_03,
  parameter int          MIN_FRAME_BYTES = 64,
  parameter int          MAX_FRAME_BYTES = 1518,
  parameter int          PREAMBLE_MIN    = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_ctrl,
  input  logic [3:0]  i_phy_rxd,
  output logic [7:0]  o_dataout,
  output logic        o_data_valid,
  output logic        o_frame_start,
  output logic        o_frame_end,
  output logic        o_frame_ok,
  output logic [10:0] o_byte_count
);

  localparam logic [10:0] CNT_MIN = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] CNT_MAX = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0] CNT_SAT = 11'(MAX_FRAME_BYTES + 1);
  localparam logic [3:0]  PRE_MIN = 4'(PREAMBLE_MIN);

  rx_state_e   r_state, w_state_nxt;
  logic        r_ctrl_prev;
  logic [3:0]  r_pre_cnt;
  logic        r_nib_phase;
  logic [3:0]  r_lo;
  logic [31:0] r_dly;
  logic [10:0] r_byte_cnt;
  logic        r_uc_ok, r_bc_ok;
  logic [47:0] r_mac_exp;

  logic        w_sfd, w_byte_done, w_end_data, w_end_drop;
  logic [7:0]  w_byte;
  logic [10:0] w_cnt_inc;
  logic        w_len_ok, w_da_ok, w_crc_ok;

  assign w_byte    = {i_phy_rxd, r_lo};
  assign w_cnt_inc = r_byte_cnt + 11'd1;
  assign w_len_ok  = (r_byte_cnt >= CNT_MIN) && (r_byte_cnt <= CNT_MAX);
  assign w_da_ok   = (r_uc_ok || r_bc_ok) && (r_byte_cnt >= 11'd6);

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] w_crc;

  eth_crc32_d4 u_crc (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_init (w_sfd),
    .i_en   ((r_state == DATA) && i_rx_ctrl),
    .i_d    (i_phy_rxd),
    .o_crc  (w_crc)
  );

  assign w_crc_ok = (w_crc == ETH_CRC_RESIDUE);
`else
  assign w_crc_ok = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sfd       = 1'b0;
    w_byte_done = 1'b0;
    w_end_data  = 1'b0;
    w_end_drop  = 1'b0;
    case (r_state)
      IDLE: begin
        // Only a rising rx_ctrl with a preamble nibble starts a frame; a link
        // already busy (e.g. just out of reset) is sat out in WAIT_IDLE.
        if (i_rx_ctrl) begin
          if (!r_ctrl_prev && (i_phy_rxd == ETH_PREAMBLE_NIB)) w_state_nxt = PREAMBLE;
          else                                                 w_state_nxt = WAIT_IDLE;
        end
      end
      PREAMBLE: begin
        if (!i_rx_ctrl) begin
          w_state_nxt = IDLE;
        end else if (i_phy_rxd == ETH_PREAMBLE_NIB) begin
          w_state_nxt = PREAMBLE;
        end else if ((i_phy_rxd == ETH_SFD_NIB) && (r_pre_cnt >= PRE_MIN)) begin
          w_state_nxt = DATA;
          w_sfd       = 1'b1;
        end else begin
          w_state_nxt = WAIT_IDLE;
        end
      end
      DATA: begin
        if (!i_rx_ctrl) begin
          w_state_nxt = IDLE;
          w_end_data  = 1'b1;
        end else if (r_nib_phase) begin
          w_byte_done = 1'b1;
          if (w_cnt_inc == CNT_SAT) w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (!i_rx_ctrl) begin
          w_state_nxt = IDLE;
          w_end_drop  = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (!i_rx_ctrl) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_ctrl_prev   <= 1'b1;
      r_pre_cnt     <= 4'd1;
      r_nib_phase   <= 1'b0;
      r_lo          <= 4'd0;
      r_dly         <= 32'd0;
      r_byte_cnt    <= 11'd0;
      r_uc_ok       <= 1'b0;
      r_bc_ok       <= 1'b0;
      r_mac_exp     <= 48'd0;
      o_dataout     <= 8'd0;
      o_data_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_frame_ok    <= 1'b0;
    end else begin
      r_ctrl_prev   <= i_rx_ctrl;
      o_data_valid  <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_frame_ok    <= 1'b0;

      // The nibble that moves IDLE->PREAMBLE is the first one counted.
      if (r_state == IDLE) begin
        r_pre_cnt <= 4'd1;
      end else if ((r_state == PREAMBLE) && (i_phy_rxd == ETH_PREAMBLE_NIB) && (r_pre_cnt != 4'hF)) begin
        r_pre_cnt <= r_pre_cnt + 4'd1;
      end

      if (w_sfd) begin
        r_byte_cnt  <= 11'd0;
        r_nib_phase <= 1'b0;
        r_dly       <= 32'd0;
        r_uc_ok     <= 1'b1;
        r_bc_ok     <= 1'b1;
        r_mac_exp   <= LOCAL_MAC;
      end

      if ((r_state == DATA) && i_rx_ctrl) begin
        r_nib_phase <= ~r_nib_phase;
        if (!r_nib_phase) r_lo <= i_phy_rxd;
      end

      if (w_byte_done) begin
        r_byte_cnt <= w_cnt_inc;
        r_dly      <= {r_dly[23:0], w_byte};
        if (r_byte_cnt < 11'd6) begin
          r_uc_ok   <= r_uc_ok & (w_byte == r_mac_exp[47:40]);
          r_bc_ok   <= r_bc_ok & (w_byte == ETH_BCAST_MAC[47:40]);
          r_mac_exp <= {r_mac_exp[39:0], 8'h00};
        end
        // Byte k leaves the delay line when byte k+4 completes; the byte that
        // hits the saturation count is not released (frame goes to DROP).
        if ((r_byte_cnt >= 11'd4) && (w_cnt_inc != CNT_SAT)) begin
          o_dataout     <= r_dly[31:24];
          o_data_valid  <= 1'b1;
          o_frame_start <= (r_byte_cnt == 11'd4);
        end
      end

      if (w_end_data) begin
        o_frame_end <= 1'b1;
        o_frame_ok  <= ~r_nib_phase & w_len_ok & w_da_ok & w_crc_ok;
      end

      if (w_end_drop) begin
        o_frame_end <= 1'b1;
      end
    end
  end

  assign o_byte_count = r_byte_cnt;

endmodule

// File: tb/tb_ethernet_rx.sv
// tb/tb_ethernet_rx.sv - directed self-checking bench for ethernet_rx
module tb_ethernet_rx;

`ifdef ETH_RX_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif
  localparam logic [47:0] MY_MAC = 48'h00_0A_35_01_02_03;
  localparam logic [47:0] BC_MAC = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_ctrl;
  logic [3:0]  rxd;
  logic [7:0]  dataout;
  logic        data_valid, frame_start, frame_end, frame_ok;
  logic [10:0] byte_count;

  ethernet_rx dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_rx_ctrl     (rx_ctrl),
    .i_phy_rxd     (rxd),
    .o_dataout     (dataout),
    .o_data_valid  (data_valid),
    .o_frame_start (frame_start),
    .o_frame_end   (frame_end),
    .o_frame_ok    (frame_ok),
    .o_byte_count  (byte_count)
  );

  always #20 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] frm[$];
  logic [7:0] rx_q[$];
  int         n_start, n_end, n_ok;
  logic       last_ok, start_first;
  logic [7:0] start_byte;
  logic [10:0] last_cnt;
  logic [22:0] rst_snap;

  always @(negedge clk) begin
    if (frame_start) begin
      n_start++;
      start_byte  = dataout;
      start_first = (rx_q.size() == 0) && data_valid;
    end
    if (data_valid) rx_q.push_back(dataout);
    if (frame_end) begin
      n_end++;
      last_ok  = frame_ok;
      last_cnt = byte_count;
      if (frame_ok) n_ok++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    rx_q.delete();
    n_start = 0; n_end = 0; n_ok = 0;
    last_ok = 1'b0; start_first = 1'b0; start_byte = 8'hxx; last_cnt = 11'h7FF;
  endtask

  function automatic logic [31:0] fcs_of_frm();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build(input logic [47:0] da, input int len);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(da[8*(5-i) +: 8]);
    for (int i = 6; i < len - 4; i++) frm.push_back(8'(i * 7 + 3));
    c = fcs_of_frm();
    frm.push_back(c[7:0]);   frm.push_back(c[15:8]);
    frm.push_back(c[23:16]); frm.push_back(c[31:24]);
  endtask

  task automatic drive(input logic c, input logic [3:0] n);
    @(negedge clk);
    rx_ctrl = c;
    rxd     = n;
  endtask

  task automatic send_frame(input int npre, input bit extra_nib, input int idle, input int rst_nib);
    int         k;
    logic [7:0] b;
    k = 0;
    for (int i = 0; i < npre; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
    for (int i = 0; i < frm.size(); i++) begin
      b = frm[i];
      for (int h = 0; h < 2; h++) begin
        @(negedge clk);
        if (k == rst_nib) rst = 1'b0;
        if (k == rst_nib + 2) begin
          rst_snap = {dataout, data_valid, frame_start, frame_end, frame_ok, byte_count};
          rst = 1'b1;
          clear_mon();
        end
        rx_ctrl = 1'b1;
        rxd     = (h == 0) ? b[3:0] : b[7:4];
        k++;
      end
    end
    if (extra_nib) drive(1'b1, 4'hA);
    for (int i = 0; i < idle; i++) drive(1'b0, 4'h0);
  endtask

  task automatic check_data(input string tag, input int exp_n);
    int nbad;
    nbad = 0;
    for (int j = 0; j < rx_q.size() && j < exp_n; j++) if (rx_q[j] !== frm[j]) nbad++;
    check_val({tag, "_nvalid"}, rx_q.size(), exp_n);
    check_val({tag, "_bytes_bad"}, nbad, 0);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; rx_ctrl = 1'b0; rxd = 4'h0;
    clear_mon();
    repeat (4) @(negedge clk);
    check_val("rst_outs", {9'd0, dataout, data_valid, frame_start, frame_end, frame_ok, byte_count}, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 1: good unicast 64-byte frame
    build(MY_MAC, 64); clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("t1", 60);
    check_val("t1_nstart", n_start, 1);
    check_val("t1_start_byte", start_byte, 8'h00);
    check_val("t1_start_first", start_first, 1);
    check_val("t1_nend", n_end, 1);
    check_val("t1_ok", last_ok, 1);
    check_val("t1_cnt", last_cnt, 64);

    // 2: payload bit flipped, FCS left alone
    build(MY_MAC, 64); frm[20] = frm[20] ^ 8'h04; clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("t2", 60);
    check_val("t2_nend", n_end, 1);
    check_val("t2_ok", last_ok, CRC_EN ? 0 : 1);

    // 3: broadcast at maximum length, then one byte over
    build(BC_MAC, 1518); clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("t3a", 1514);
    check_val("t3a_ok", last_ok, 1);
    check_val("t3a_cnt", last_cnt, 1518);
    build(BC_MAC, 1519); clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("t3b", 1514);
    check_val("t3b_nend", n_end, 1);
    check_val("t3b_ok", last_ok, 0);
    check_val("t3b_cnt", last_cnt, 1519);

    // below minimum length
    build(MY_MAC, 63); clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("tmin", 59);
    check_val("tmin_ok", last_ok, 0);
    check_val("tmin_cnt", last_cnt, 63);

    // 4: broken preamble, then short preamble, then a normal frame
    clear_mon();
    drive(1'b1, 4'h5); drive(1'b1, 4'h5); drive(1'b1, 4'h3);
    for (int i = 0; i < 10; i++) drive(1'b1, 4'(i));
    for (int i = 0; i < 6; i++) drive(1'b0, 4'h0);
    check_val("t4_nvalid", rx_q.size(), 0);
    check_val("t4_nend", n_end, 0);
    build(MY_MAC, 64); clear_mon();
    send_frame(6, 1'b0, 12, -10);
    check_val("t4_shortpre_nvalid", rx_q.size(), 0);
    check_val("t4_shortpre_nend", n_end, 0);
    clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("t4_next", 60);
    check_val("t4_next_ok", last_ok, 1);

    // 5: odd nibble count, DA mismatch
    build(MY_MAC, 64); clear_mon();
    send_frame(7, 1'b1, 12, -10);
    check_val("t5_odd_nend", n_end, 1);
    check_val("t5_odd_ok", last_ok, 0);
    check_val("t5_odd_cnt", last_cnt, 64);
    build(48'h00_0A_35_01_02_04, 64); clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("t5_da", 60);
    check_val("t5_da_nend", n_end, 1);
    check_val("t5_da_ok", last_ok, 0);

    // back-to-back: next preamble begins in the frame_end cycle
    build(MY_MAC, 64); clear_mon();
    send_frame(7, 1'b0, 1, -10);
    send_frame(7, 1'b0, 12, -10);
    check_val("b2b_nvalid", rx_q.size(), 120);
    check_val("b2b_nstart", n_start, 2);
    check_val("b2b_nend", n_end, 2);
    check_val("b2b_nok", n_ok, 2);

    // 6: reset for 2 cycles mid-DATA with rx_ctrl held high
    build(MY_MAC, 64); clear_mon();
    send_frame(7, 1'b0, 12, 40);
    check_val("t6_rst_outs", {9'd0, rst_snap}, 0);
    check_val("t6_nvalid", rx_q.size(), 0);
    check_val("t6_nend", n_end, 0);
    clear_mon();
    send_frame(7, 1'b0, 12, -10);
    check_data("t6_next", 60);
    check_val("t6_next_ok", last_ok, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
